// File: rtl/fsm_sar_mc.sv
// -----------------------------------------------------------------------------
// fsm_sar_mc
//
// Multi-channel successive-approximation (SAR) conversion controller. It scans
// a masked set of analog channels in ascending order. For each channel it
// drives the analog mux select and the sample/hold switch. It then runs a
// Width-bit binary search of the trial DAC code against an external comparator.
// Each finished code is handed out through a valid/ready output register that
// is tagged with its channel number.
//
// Optional feature (macro SAR_CONT_SCAN_EN):
//   When defined, the block gains an input cont_i. If cont_i is high at the end
//   of a scan, the FSM pulses eoc_o and restarts on the lowest latched channel
//   instead of returning to IDLE. When undefined, every scan is single-shot.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-high reset
//   cont_i          (SAR_CONT_SCAN_EN only) keep scanning at end of scan
//   start_i         start a scan; only looked at while IDLE
//   ch_mask_i       channels to convert, latched when the scan starts
//   cmp_i           comparator, 1 = Vin >= DAC
//   sample_o        sample/hold switch control
//   ch_sel_o        analog mux select
//   dac_o           trial DAC code
//   result_o        converted code
//   result_ch_o     channel that result_o belongs to
//   result_valid_o  result_o/result_ch_o hold a result not yet taken
//   result_ready_i  consumer accepts the current result
//   busy_o          high in every state except IDLE
//   eoc_o           one-cycle pulse when the last channel's result loads
// -----------------------------------------------------------------------------
module fsm_sar_mc #(
    parameter int Width        = 8,
    parameter int Channels     = 4,
    parameter int SampleCycles = 2,
    parameter int SettleCycles = 2,
    localparam int ChW         = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
`ifdef SAR_CONT_SCAN_EN
    input  logic                cont_i,
`endif
    input  logic                start_i,
    input  logic [Channels-1:0] ch_mask_i,
    input  logic                cmp_i,
    output logic                sample_o,
    output logic [ChW-1:0]      ch_sel_o,
    output logic [Width-1:0]    dac_o,
    output logic [Width-1:0]    result_o,
    output logic [ChW-1:0]      result_ch_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic                busy_o,
    output logic                eoc_o
);

    localparam int BitW = $clog2(Width);
    localparam int CntW = 16;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        COMPARE,
        STORE
    } state_e;

    state_e              state_q, state_d;
    logic [Channels-1:0] mask_q, mask_d;
    logic [ChW-1:0]      ch_sel_q, ch_sel_d;
    logic [Width-1:0]    dac_q, dac_d;
    logic [BitW-1:0]     bit_q, bit_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [Width-1:0]    result_q, result_d;
    logic [ChW-1:0]      result_ch_q, result_ch_d;
    logic                result_valid_q, result_valid_d;
    logic                eoc_q, eoc_d;

    // Returns the lowest set channel at or above 'from' in 'm'. The MSB is a
    // found flag and the remaining bits are the channel number. Walking the
    // loop downwards lets the lowest match win.
    function automatic logic [ChW:0] next_set(input logic [Channels-1:0] m,
                                              input int from);
        logic [ChW:0] r;
        r = '0;
        for (int i = Channels - 1; i >= 0; i--) begin
            if (i >= from && m[i]) begin
                r = {1'b1, ChW'(i)};
            end
        end
        return r;
    endfunction

    logic [ChW:0] start_ch;
    logic [ChW:0] after_ch;
`ifdef SAR_CONT_SCAN_EN
    logic [ChW:0] first_ch;
`endif

    // Channel lookups. start_ch picks the first channel of a new scan from the
    // live mask. after_ch looks past the current channel in the latched mask,
    // so changes on ch_mask_i during a scan are never seen.
    always_comb begin
        start_ch = next_set(ch_mask_i, 0);
        after_ch = next_set(mask_q, int'(ch_sel_q) + 1);
`ifdef SAR_CONT_SCAN_EN
        first_ch = next_set(mask_q, 0);
`endif
    end

    // Next-state and datapath logic for the scan FSM. The output register
    // drops valid when the consumer takes it. STORE may reload it on that same
    // edge, so a taken result can be replaced back-to-back. A result that has
    // not been taken is never overwritten: STORE simply waits.
    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        ch_sel_d       = ch_sel_q;
        dac_d          = dac_q;
        bit_d          = bit_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        result_ch_d    = result_ch_q;
        result_valid_d = result_valid_q && !result_ready_i;
        eoc_d          = 1'b0;

        case (state_q)
            IDLE: begin
                dac_d = '0;
                cnt_d = '0;
                if (start_i && start_ch[ChW]) begin
                    mask_d   = ch_mask_i;
                    ch_sel_d = start_ch[ChW-1:0];
                    state_d  = SAMPLE;
                end
            end

            SAMPLE: begin
                if (cnt_q == CntW'(SampleCycles - 1)) begin
                    cnt_d   = '0;
                    bit_d   = BitW'(Width - 1);
                    dac_d   = {1'b1, {(Width-1){1'b0}}};
                    state_d = (SettleCycles == 0) ? COMPARE : SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SETTLE: begin
                if (cnt_q == CntW'(SettleCycles - 1)) begin
                    cnt_d   = '0;
                    state_d = COMPARE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            COMPARE: begin
                if (!cmp_i) begin
                    dac_d[bit_q] = 1'b0;
                end
                if (bit_q != '0) begin
                    dac_d[bit_q - 1'b1] = 1'b1;
                    bit_d   = bit_q - 1'b1;
                    state_d = (SettleCycles == 0) ? COMPARE : SETTLE;
                end else begin
                    state_d = STORE;
                end
            end

            STORE: begin
                if (!result_valid_q || result_ready_i) begin
                    result_d       = dac_q;
                    result_ch_d    = ch_sel_q;
                    result_valid_d = 1'b1;
                    dac_d          = '0;
                    if (after_ch[ChW]) begin
                        ch_sel_d = after_ch[ChW-1:0];
                        state_d  = SAMPLE;
                    end else begin
                        eoc_d   = 1'b1;
                        state_d = IDLE;
`ifdef SAR_CONT_SCAN_EN
                        if (cont_i && first_ch[ChW]) begin
                            ch_sel_d = first_ch[ChW-1:0];
                            state_d  = SAMPLE;
                        end
`endif
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset is asynchronous. It returns the FSM
    // to IDLE and clears every output, which drops any pending result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            mask_q         <= '0;
            ch_sel_q       <= '0;
            dac_q          <= '0;
            bit_q          <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_ch_q    <= '0;
            result_valid_q <= 1'b0;
            eoc_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            ch_sel_q       <= ch_sel_d;
            dac_q          <= dac_d;
            bit_q          <= bit_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_ch_q    <= result_ch_d;
            result_valid_q <= result_valid_d;
            eoc_q          <= eoc_d;
        end
    end

    // sample_o and busy_o decode directly from the state register. Because of
    // that, both go low as soon as reset forces IDLE.
    always_comb begin
        sample_o       = (state_q == SAMPLE);
        busy_o         = (state_q != IDLE);
        ch_sel_o       = ch_sel_q;
        dac_o          = dac_q;
        result_o       = result_q;
        result_ch_o    = result_ch_q;
        result_valid_o = result_valid_q;
        eoc_o          = eoc_q;
    end

endmodule

// File: tb/tb_fsm_sar_mc.sv
// -----------------------------------------------------------------------------
// tb_fsm_sar_mc
//
// Testbench for fsm_sar_mc with Width=8, Channels=4, SampleCycles=2 and
// SettleCycles=2. Each channel has an ideal comparator: cmp_i is high when the
// channel's input code is at least the DAC code. With an ideal comparator the
// expected conversion is simply that input code. The expected stream is the
// set channels of the mask, in ascending order, each with its input code.
// -----------------------------------------------------------------------------
module tb_fsm_sar_mc;

    localparam int W = 8;
    localparam int C = 4;
    localparam int S = 2;
    localparam int T = 2;
    localparam int LATENCY = S + W * (T + 1) + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [C-1:0] mask;
    logic         cmp;
    logic         sample;
    logic [1:0]   ch_sel;
    logic [W-1:0] dac;
    logic [W-1:0] res;
    logic [1:0]   res_ch;
    logic         valid;
    logic         ready;
    logic         busy;
    logic         eoc;
`ifdef SAR_CONT_SCAN_EN
    logic         cont;
`endif

    logic [W-1:0] vin [C];

    int vectors;
    int miscompares;

    fsm_sar_mc #(
        .Width(W), .Channels(C), .SampleCycles(S), .SettleCycles(T)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
`ifdef SAR_CONT_SCAN_EN
        .cont_i         (cont),
`endif
        .start_i        (start),
        .ch_mask_i      (mask),
        .cmp_i          (cmp),
        .sample_o       (sample),
        .ch_sel_o       (ch_sel),
        .dac_o          (dac),
        .result_o       (res),
        .result_ch_o    (res_ch),
        .result_valid_o (valid),
        .result_ready_i (ready),
        .busy_o         (busy),
        .eoc_o          (eoc)
    );

    // Ideal comparator for whichever channel the mux currently selects.
    assign cmp = (vin[ch_sel] >= dac);

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hold reset for a few cycles and confirm every output reads zero.
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({sample, ch_sel, dac, res, res_ch, valid, busy, eoc} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got=%h want=0",
                     {sample, ch_sel, dac, res, res_ch, valid, busy, eoc});
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle busy=%b want=0", busy);
        end
    endtask

    // Single channel 0 with Vin=0xA5 and ready held high. Checks the latency,
    // the code, the tag, the eoc pulse, the sample width and the return to idle.
    task automatic test_single();
        int n;
        int samples;
        int eocs;
        vin[0] = 8'hA5;
        ready  = 1'b1;
        @(negedge clk);
        mask  = 4'b0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        samples = sample ? 1 : 0;
        eocs    = 0;
        n       = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (sample) samples++;
            if (valid) break;
            if (eoc) eocs++;
        end
        vectors++;
        if (n !== LATENCY) begin
            miscompares++;
            $display("[TB] FAIL single_latency got=%0d want=%0d", n, LATENCY);
        end
        vectors++;
        if ({valid, res_ch, res} !== {1'b1, 2'd0, 8'hA5}) begin
            miscompares++;
            $display("[TB] FAIL single_result got=%b/%0d/%h want=1/0/a5",
                     valid, res_ch, res);
        end
        vectors++;
        if ({eoc, busy} !== 2'b10 || eocs !== 0) begin
            miscompares++;
            $display("[TB] FAIL single_eoc eoc=%b busy=%b early_eocs=%0d want=1/0/0",
                     eoc, busy, eocs);
        end
        vectors++;
        if (samples !== S) begin
            miscompares++;
            $display("[TB] FAIL single_sample_cycles got=%0d want=%0d", samples, S);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({valid, eoc, busy} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL single_after valid/eoc/busy=%b want=000",
                     {valid, eoc, busy});
        end
    endtask

    // Runs one scan of mask m against the reference stream. Ready is high with
    // probability ready_pct percent each cycle. With wiggle set, start is
    // re-pulsed while busy and ch_mask_i is scrambled; neither may affect the
    // scan.
    task automatic test_scan(input logic [C-1:0] m, input int ready_pct,
                             input bit wiggle);
        int          exp_ch[$];
        int          last_ch;
        int          eocs;
        int          cycles;
        bit          held;
        bit          rdy;
        logic [W-1:0] held_res;
        logic [1:0]  held_ch;
        logic [1:0]  ec;
        for (int i = 0; i < C; i++) if (m[i]) exp_ch.push_back(i);
        last_ch = exp_ch[exp_ch.size() - 1];
        eocs    = 0;
        cycles  = 0;
        held    = 1'b0;
        held_res = '0;
        held_ch  = '0;
        @(negedge clk);
        mask  = m;
        start = 1'b1;
        ready = 1'b0;
        while (cycles < 3000) begin
            @(negedge clk);
            cycles++;
            start = (wiggle && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (wiggle) mask = 4'($urandom);
            if (held) begin
                vectors++;
                if ({valid, res_ch, res} !== {1'b1, held_ch, held_res}) begin
                    miscompares++;
                    $display("[TB] FAIL scan_hold got=%b/%0d/%h want=1/%0d/%h",
                             valid, res_ch, res, held_ch, held_res);
                end
            end
            if (eoc) begin
                eocs++;
                vectors++;
                if ({valid, res_ch} !== {1'b1, 2'(last_ch)}) begin
                    miscompares++;
                    $display("[TB] FAIL scan_eoc_with_last valid/ch=%b/%0d want=1/%0d",
                             valid, res_ch, last_ch);
                end
            end
            if (busy) begin
                vectors++;
                if (m[ch_sel] !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL scan_ch_sel got=%0d mask=%b", ch_sel, m);
                end
            end
            rdy   = ($urandom_range(0, 99) < ready_pct);
            ready = rdy;
            if (valid && rdy) begin
                vectors++;
                if (exp_ch.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL scan_extra_result got=%0d/%h want=none",
                             res_ch, res);
                end else begin
                    ec = 2'(exp_ch[0]);
                    if ({res_ch, res} !== {ec, vin[exp_ch[0]]}) begin
                        miscompares++;
                        $display("[TB] FAIL scan_result got=%0d/%h want=%0d/%h",
                                 res_ch, res, ec, vin[exp_ch[0]]);
                    end
                    void'(exp_ch.pop_front());
                end
            end
            held     = valid && !rdy;
            held_res = res;
            held_ch  = res_ch;
            if (exp_ch.size() == 0 && !busy) break;
        end
        start = 1'b0;
        ready = 1'b1;
        mask  = m;
        vectors++;
        if (exp_ch.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL scan_timeout missing=%0d want=0", exp_ch.size());
        end
        vectors++;
        if (eocs !== 1) begin
            miscompares++;
            $display("[TB] FAIL scan_eoc_count got=%0d want=1", eocs);
        end
        @(negedge clk);
        vectors++;
        if ({valid, busy, eoc} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL scan_end valid/busy/eoc=%b want=000",
                     {valid, busy, eoc});
        end
    endtask

    // Channels 1 and 3 at the comparator extremes (all-zero and all-one codes).
    task automatic test_two_channel();
        vin[1] = 8'h00;
        vin[3] = 8'hFF;
        test_scan(4'b1010, 100, 1'b0);
    endtask

    // Ready is held low for 50 cycles. The first result must sit unchanged and
    // the FSM must stall in STORE with no eoc. Releasing ready must deliver the
    // second result on the same edge as eoc.
    task automatic test_backpressure();
        int n;
        logic [W-1:0] r0;
        logic [1:0]   c0;
        int           bad;
        vin[0] = 8'($urandom);
        vin[1] = 8'($urandom);
        ready  = 1'b0;
        @(negedge clk);
        mask  = 4'b0011;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        r0  = res;
        c0  = res_ch;
        vectors++;
        if ({valid, c0, r0} !== {1'b1, 2'd0, vin[0]}) begin
            miscompares++;
            $display("[TB] FAIL bp_first got=%b/%0d/%h want=1/0/%h",
                     valid, c0, r0, vin[0]);
        end
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if ({valid, res_ch, res} !== {1'b1, c0, r0} || eoc !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL bp_stable bad_cycles=%0d want=0", bad);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_stalled busy=%b want=1", busy);
        end
        ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({valid, eoc, res_ch, res} !== {1'b1, 1'b1, 2'd1, vin[1]}) begin
            miscompares++;
            $display("[TB] FAIL bp_second got=%b/%b/%0d/%h want=1/1/1/%h",
                     valid, eoc, res_ch, res, vin[1]);
        end
        @(negedge clk);
        vectors++;
        if ({valid, eoc, busy} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL bp_end valid/eoc/busy=%b want=000",
                     {valid, eoc, busy});
        end
    endtask

    // Reset is asserted in the middle of channel 1's first compare cycle. The
    // outputs must clear without waiting for a clock edge, and a fresh scan
    // must work afterwards.
    task automatic test_reset_mid();
        vin[1] = 8'($urandom);
        ready  = 1'b1;
        @(negedge clk);
        mask  = 4'b0010;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (S + T) @(posedge clk);
        #2;
        vectors++;
        if ({busy, ch_sel, dac} !== {1'b1, 2'd1, 8'h80}) begin
            miscompares++;
            $display("[TB] FAIL midrst_pre got=%b/%0d/%h want=1/1/80",
                     busy, ch_sel, dac);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({sample, ch_sel, dac, res, res_ch, valid, busy, eoc} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midrst_async got=%h want=0",
                     {sample, ch_sel, dac, res, res_ch, valid, busy, eoc});
        end
        @(negedge clk);
        rst = 1'b0;
        test_scan(4'b0010, 100, 1'b0);
    endtask

    // A start with an empty mask must be ignored.
    task automatic test_mask_zero();
        int bad;
        bad = 0;
        @(negedge clk);
        mask  = 4'b0000;
        start = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (busy !== 1'b0 || valid !== 1'b0) bad++;
        end
        start = 1'b0;
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL mask_zero busy_cycles=%0d want=0", bad);
        end
    endtask

    // Random masks, random input codes, random backpressure, re-pulsed start
    // while busy and a scrambled live mask.
    task automatic test_random();
        logic [C-1:0] m;
        repeat (8) begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < C; i++) vin[i] = 8'($urandom);
            test_scan(m, int'($urandom_range(30, 100)), 1'b1);
        end
    endtask

`ifdef SAR_CONT_SCAN_EN
    // Continuous scanning of channel 0: eoc every LATENCY cycles with busy
    // never dropping. Clearing cont_i then lets the current scan finish and
    // return to IDLE.
    task automatic test_cont();
        int n;
        int last;
        int eocs;
        int bad;
        vin[0] = 8'($urandom);
        ready  = 1'b1;
        cont   = 1'b1;
        @(negedge clk);
        mask  = 4'b0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0; last = 0; eocs = 0; bad = 0;
        while (n < 500 && eocs < 4) begin
            @(posedge clk);
            #1;
            n++;
            if (eoc) begin
                eocs++;
                if (n - last !== LATENCY || res !== vin[0]) bad++;
                last = n;
                if (eocs == 3) cont = 1'b0;
                if (eocs == 4) begin
                    vectors++;
                    if (busy !== 1'b0) begin
                        miscompares++;
                        $display("[TB] FAIL cont_stop busy=%b want=0", busy);
                    end
                end
            end else if (busy !== 1'b1) begin
                bad++;
            end
        end
        vectors++;
        if (bad !== 0 || eocs !== 4) begin
            miscompares++;
            $display("[TB] FAIL cont_period bad=%0d eocs=%0d want=0/4", bad, eocs);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        mask        = '0;
        ready       = 1'b0;
`ifdef SAR_CONT_SCAN_EN
        cont        = 1'b0;
`endif
        for (int i = 0; i < C; i++) vin[i] = '0;
        test_reset();
        test_single();
        test_two_channel();
        test_backpressure();
        test_reset_mid();
        test_mask_zero();
        test_random();
`ifdef SAR_CONT_SCAN_EN
        test_cont();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fsm_sar_mc.md
Name: fsm_sar_mc

Overview:
Parametrised multi-channel successor to the single-channel SAR binary-search FSM. It scans a masked set of analog channels and drives the channel mux, sample switch and trial DAC code for each one. Each channel gets a Width-bit binary-search conversion against an external comparator. Results are delivered through a valid/ready output register tagged with the channel number.

Parameters:
Width, 8, conversion resolution in bits (2..16)
Channels, 4, number of analog channels (1..16)
SampleCycles, 2, cycles sample_o is held high per channel (>=1)
SettleCycles, 2, DAC settling cycles before each comparison (>=0)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  start a scan (level-sampled in IDLE)
ch_mask_i  in  Channels  channels to convert; latched on start
cmp_i  in  1  comparator: 1 = Vin >= DAC
sample_o  out  1  sample/hold switch control
ch_sel_o  out  max(1,$clog2(Channels))  analog mux select
dac_o  out  Width  trial DAC code
result_o  out  Width  converted code
result_ch_o  out  max(1,$clog2(Channels))  channel of result_o
result_valid_o  out  1  result_o/result_ch_o valid
result_ready_i  in  1  consumer accepts result
busy_o  out  1  high in any state except IDLE
eoc_o  out  1  one-cycle pulse: scan complete

Behaviour:
- Reset (async, any state): FSM to IDLE; all outputs 0; latched mask, bit index and counters cleared; any pending result dropped.
- States: IDLE, SAMPLE, SETTLE, COMPARE, STORE.
- IDLE: dac_o=0, sample_o=0.
  - start_i=1 with ch_mask_i!=0: latch mask, set ch_sel_o to the lowest set channel, go to SAMPLE.
  - start_i with mask 0 is ignored.
  - start_i outside IDLE is ignored.
- SAMPLE: sample_o=1 for SampleCycles cycles, dac_o=0. Then go to SETTLE with dac_o = 1<<(Width-1), bit index = Width-1.
- SETTLE: hold dac_o for SettleCycles cycles. With SettleCycles=0, go straight to COMPARE.
- COMPARE (1 cycle): sample cmp_i.
  - cmp_i=0: clear the bit under test.
  - Bit index >0: set the next lower bit in dac_o, go to SETTLE.
  - Bit index 0: go to STORE.
- STORE:
  - If !result_valid_o || result_ready_i: load result_o = final code, result_ch_o = ch_sel_o, result_valid_o=1.
  - Then advance to the next higher set channel in the latched mask (go to SAMPLE).
  - If no set channel remains: pulse eoc_o, go to IDLE.
  - Otherwise stall in STORE (backpressure); no result is ever overwritten.
- Output handshake:
  - result_valid_o falls on the edge where result_ready_i=1, unless a new result loads on that same edge. In that case valid stays 1 with the new data.
  - result_o and result_ch_o stay stable while valid && !ready.
- Latency: result_valid_o rises SampleCycles + Width*(SettleCycles+1) + 1 edges after the edge sampling start_i, given no backpressure.
- eoc_o is asserted on the same edge as the final result loads.
- ch_sel_o stays stable from SAMPLE through STORE of a channel.
- busy_o=0 only in IDLE. Pending result_valid_o may outlive busy_o.
- Channel change: ch_mask_i changes mid-scan have no effect.
- Comparator edge cases: all-ones cmp_i gives code 2^Width-1; all-zeros gives 0.

Optional Feature:
Macro SAR_CONT_SCAN_EN.
- Defined: adds input port cont_i (1 bit).
  - At end of scan with cont_i=1: eoc_o still pulses, then the FSM goes to SAMPLE on the lowest set channel of the latched mask instead of IDLE. busy_o stays 1.
  - cont_i=0 at end of scan: return to IDLE.
  - Deasserting cont_i mid-scan finishes the current scan.
- Undefined: no cont_i port; every scan is single-shot.

Test Plan:
- Width=8, Settle=2, Sample=2, mask=4'b0001. Comparator model cmp_i = (0xA5 >= dac_o), start pulse, ready=1 -> result_o=0xA5, result_ch_o=0, valid rises 27 edges after start, eoc_o pulses once, busy_o returns 0.
- mask=4'b1010, per-channel Vin ch1=0x00, ch3=0xFF -> results in order (ch1,0x00), (ch3,0xFF); ch_sel_o visits only 1 then 3; a single eoc_o pulse with the ch3 result.
- ready=0 held for 50 cycles during a 2-channel scan -> first result stays stable, FSM stalls in STORE for channel 2, no eoc_o. Assert ready -> second result delivered, then eoc_o.
- Assert rst_i mid-COMPARE of channel 1 -> all outputs 0 immediately (asynchronous), FSM in IDLE. Next start works normally.
- Edge cases: start with mask=0 ignored (busy_o stays 0); start_i pulsed while busy ignored; ch_mask_i toggled mid-scan has no effect.
- With SAR_CONT_SCAN_EN and cont_i=1, mask=4'b0001 -> eoc_o every 27 cycles with busy_o continuously 1. Drop cont_i -> IDLE after the current scan.
